// File: rtl/cpu_pipe_pkg.sv
// Shared constants and control-bundle type for the pipelined MIPS CPU stages.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned ALUC_W_DEF = 6;
  localparam int unsigned TAG_W_DEF  = 4;

  typedef struct packed {
    logic                  wreg;
    logic                  m2reg;
    logic                  wmem;
    logic                  shift;
    logic                  aluimm;
    logic                  branch;
    logic [ALUC_W_DEF-1:0] aluc;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with synchronous reset and clear.
module sat_event_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with stall, flush (bubble) and saturating event counters.
module id_exe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned ALUC_W = ALUC_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              id_valid,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              id_wmem,
  input  logic              id_shift,
  input  logic              id_aluimm,
  input  logic              id_branch,
  input  logic [ALUC_W-1:0] id_aluc,
  input  logic [DATA_W-1:0] id_data_a,
  input  logic [DATA_W-1:0] id_data_b,
  input  logic [DATA_W-1:0] id_data_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_W-1:0]  id_destR,
  input  logic [TAG_W-1:0]  id_ins_type,
  input  logic [TAG_W-1:0]  id_ins_number,
  output logic              ex_valid,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              eshift,
  output logic              ealuimm,
  output logic              e_branch,
  output logic [ALUC_W-1:0] ealuc,
  output logic [DATA_W-1:0] odata_a,
  output logic [DATA_W-1:0] odata_b,
  output logic [DATA_W-1:0] odata_imm,
  output logic [DATA_W-1:0] e_pc4,
  output logic [REG_W-1:0]  ex_destR,
  output logic [TAG_W-1:0]  EXE_ins_type,
  output logic [TAG_W-1:0]  EXE_ins_number,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [ALUC_W-1:0] aluc_q, aluc_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic [DATA_W-1:0] data_imm_q, data_imm_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [TAG_W-1:0]  type_q, type_d;
  logic [TAG_W-1:0]  number_q, number_d;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    aluc_d     = aluc_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    data_imm_d = data_imm_q;
    pc4_d      = pc4_q;
    dest_d     = dest_q;
    type_d     = type_q;
    number_d   = number_q;
    if (flush) begin
      // Bubble only kills the side-effecting controls; datapath fields keep their value.
      valid_d       = 1'b0;
      ctrl_d.wreg   = BUBBLE_CTRL.wreg;
      ctrl_d.m2reg  = BUBBLE_CTRL.m2reg;
      ctrl_d.wmem   = BUBBLE_CTRL.wmem;
      ctrl_d.branch = BUBBLE_CTRL.branch;
    end else if (!stall) begin
      valid_d       = id_valid;
      ctrl_d.wreg   = id_valid & id_wreg;
      ctrl_d.m2reg  = id_valid & id_m2reg;
      ctrl_d.wmem   = id_valid & id_wmem;
      ctrl_d.branch = id_valid & id_branch;
      ctrl_d.shift  = id_shift;
      ctrl_d.aluimm = id_aluimm;
      ctrl_d.aluc   = '0;
      aluc_d        = id_aluc;
      data_a_d      = id_data_a;
      data_b_d      = id_data_b;
      data_imm_d    = id_data_imm;
      pc4_d         = id_pc4;
      dest_d        = id_destR;
      type_d        = id_ins_type;
      number_d      = id_ins_number;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= BUBBLE_CTRL;
      aluc_q     <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      data_imm_q <= '0;
      pc4_q      <= '0;
      dest_q     <= '0;
      type_q     <= '0;
      number_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      aluc_q     <= aluc_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      data_imm_q <= data_imm_d;
      pc4_q      <= pc4_d;
      dest_q     <= dest_d;
      type_q     <= type_d;
      number_q   <= number_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ewreg          = ctrl_q.wreg;
  assign em2reg         = ctrl_q.m2reg;
  assign ewmem          = ctrl_q.wmem;
  assign eshift         = ctrl_q.shift;
  assign ealuimm        = ctrl_q.aluimm;
  assign e_branch       = ctrl_q.branch;
  assign ealuc          = aluc_q;
  assign odata_a        = data_a_q;
  assign odata_b        = data_b_q;
  assign odata_imm      = data_imm_q;
  assign e_pc4          = pc4_q;
  assign ex_destR       = dest_q;
  assign EXE_ins_type   = type_q;
  assign EXE_ins_number = number_q;

  sat_event_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall & ~flush),
    .clr  (cnt_clr),
    .count(stall_cnt)
  );

  sat_event_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (flush),
    .clr  (cnt_clr),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg; a second instance with CNT_W=3 covers saturation.
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, cnt_clr, id_valid;
  logic        id_wreg, id_m2reg, id_wmem, id_shift, id_aluimm, id_branch;
  logic [5:0]  id_aluc;
  logic [31:0] id_data_a, id_data_b, id_data_imm, id_pc4;
  logic [4:0]  id_destR;
  logic [3:0]  id_ins_type, id_ins_number;

  logic        ex_valid, ewreg, em2reg, ewmem, eshift, ealuimm, e_branch;
  logic [5:0]  ealuc;
  logic [31:0] odata_a, odata_b, odata_imm, e_pc4;
  logic [4:0]  ex_destR;
  logic [3:0]  exe_type, exe_number;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid, s_wreg, s_m2reg, s_wmem, s_shift, s_aluimm, s_branch;
  logic [5:0]  s_aluc;
  logic [31:0] s_a, s_b, s_imm, s_pc4;
  logic [4:0]  s_dest;
  logic [3:0]  s_type, s_number;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .id_valid(id_valid), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_shift(id_shift), .id_aluimm(id_aluimm), .id_branch(id_branch), .id_aluc(id_aluc),
    .id_data_a(id_data_a), .id_data_b(id_data_b), .id_data_imm(id_data_imm),
    .id_pc4(id_pc4), .id_destR(id_destR), .id_ins_type(id_ins_type),
    .id_ins_number(id_ins_number), .ex_valid(ex_valid), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .eshift(eshift), .ealuimm(ealuimm), .e_branch(e_branch), .ealuc(ealuc),
    .odata_a(odata_a), .odata_b(odata_b), .odata_imm(odata_imm), .e_pc4(e_pc4),
    .ex_destR(ex_destR), .EXE_ins_type(exe_type), .EXE_ins_number(exe_number),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_stage_reg #(
    .CNT_W(3)
  ) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .id_valid(id_valid), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_shift(id_shift), .id_aluimm(id_aluimm), .id_branch(id_branch), .id_aluc(id_aluc),
    .id_data_a(id_data_a), .id_data_b(id_data_b), .id_data_imm(id_data_imm),
    .id_pc4(id_pc4), .id_destR(id_destR), .id_ins_type(id_ins_type),
    .id_ins_number(id_ins_number), .ex_valid(s_valid), .ewreg(s_wreg), .em2reg(s_m2reg),
    .ewmem(s_wmem), .eshift(s_shift), .ealuimm(s_aluimm), .e_branch(s_branch),
    .ealuc(s_aluc), .odata_a(s_a), .odata_b(s_b), .odata_imm(s_imm), .e_pc4(s_pc4),
    .ex_destR(s_dest), .EXE_ins_type(s_type), .EXE_ins_number(s_number),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    id_valid = 1'b1; id_wreg = 1'b1; id_m2reg = 1'b1; id_wmem = 1'b1;
    id_shift = 1'b1; id_aluimm = 1'b1; id_branch = 1'b1; id_aluc = 6'h3f;
    id_data_a = 32'hFFFF_FFFF; id_data_b = 32'h5555_5555; id_data_imm = 32'h0000_00FF;
    id_pc4 = 32'h0040_0004; id_destR = 5'd7; id_ins_type = 4'hA; id_ins_number = 4'h5;
    #1;
    step(); step();

    // Reset with nonzero inputs
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ctrl", {57'd0, ewreg, em2reg, ewmem, eshift, ealuimm, e_branch, s_valid}, 64'd0);
    chk("rst_aluc", {58'd0, ealuc}, 64'd0);
    chk("rst_data", {odata_a, odata_b}, 64'd0);
    chk("rst_imm_pc4", {odata_imm, e_pc4}, 64'd0);
    chk("rst_dest_tags", {51'd0, ex_destR, exe_type, exe_number}, 64'd0);
    chk("rst_cnts", {32'd0, stall_cnt, flush_cnt}, 64'd0);

    // Release and load the first instruction
    rst = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0; id_branch = 1'b0; id_shift = 1'b0;
    id_aluimm = 1'b0; id_aluc = 6'h01;
    id_data_a = 32'h1234_5678; id_destR = 5'd31; id_data_b = 32'hAAAA_0001;
    step();
    chk("load_ewreg", {63'd0, ewreg}, 64'd1);
    chk("load_data_a", {32'd0, odata_a}, {32'd0, 32'h1234_5678});
    chk("load_destR", {59'd0, ex_destR}, 64'd31);
    chk("load_valid", {63'd0, ex_valid}, 64'd1);
    chk("load_data_b", {32'd0, odata_b}, {32'd0, 32'hAAAA_0001});
    chk("load_tags", {56'd0, exe_type, exe_number}, 64'hA5);

    // Three-cycle stall holds A
    stall = 1'b1; id_data_b = 32'hBBBB_0002; id_data_a = 32'h0BAD_0BAD;
    step(); step(); step();
    chk("stall_hold_b", {32'd0, odata_b}, {32'd0, 32'hAAAA_0001});
    chk("stall_hold_a", {32'd0, odata_a}, {32'd0, 32'h1234_5678});
    chk("stall_cnt3", {48'd0, stall_cnt}, 64'd3);
    stall = 1'b0; id_data_a = 32'h1234_5678;
    step();
    chk("unstall_b", {32'd0, odata_b}, {32'd0, 32'hBBBB_0002});
    chk("unstall_cnt", {48'd0, stall_cnt}, 64'd3);

    // Flush beats a simultaneous stall
    id_wmem = 1'b1;
    step();
    chk("wmem_loaded", {63'd0, ewmem}, 64'd1);
    flush = 1'b1; stall = 1'b1; id_data_a = 32'hDEAD_0000;
    step();
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_ctrl", {60'd0, ewreg, em2reg, ewmem, e_branch}, 64'd0);
    chk("flush_hold_a", {32'd0, odata_a}, {32'd0, 32'h1234_5678});
    chk("flush_cnt1", {48'd0, flush_cnt}, 64'd1);
    chk("flush_stall_cnt", {48'd0, stall_cnt}, 64'd3);

    // Invalid load drops side-effecting controls but loads the rest
    flush = 1'b0; stall = 1'b0;
    id_valid = 1'b0; id_wreg = 1'b1; id_wmem = 1'b1; id_branch = 1'b1; id_m2reg = 1'b1;
    id_shift = 1'b1; id_aluc = 6'h2A;
    step();
    chk("inv_valid", {63'd0, ex_valid}, 64'd0);
    chk("inv_ctrl", {60'd0, ewreg, em2reg, ewmem, e_branch}, 64'd0);
    chk("inv_aluc", {58'd0, ealuc}, 64'h2A);
    chk("inv_shift", {63'd0, eshift}, 64'd1);
    chk("inv_data_a", {32'd0, odata_a}, {32'd0, 32'hDEAD_0000});

    // Saturation on the 3-bit counter instance
    cnt_clr = 1'b1;
    step();
    chk("clr_cnts3", {58'd0, s_stall_cnt, s_flush_cnt}, 64'd0);
    cnt_clr = 1'b0; stall = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("sat_reach7", {61'd0, s_stall_cnt}, 64'd7);
    step(); step(); step();
    chk("sat_stay7", {61'd0, s_stall_cnt}, 64'd7);
    chk("wide_cnt10", {48'd0, stall_cnt}, 64'd10);
    cnt_clr = 1'b1;
    step();
    chk("clr_over_inc3", {61'd0, s_stall_cnt}, 64'd0);
    chk("clr_over_inc", {48'd0, stall_cnt}, 64'd0);
    chk("clr_keeps_fields", {32'd0, odata_a}, {32'd0, 32'hDEAD_0000});

    // Reset in the middle of a stall with counters nonzero
    cnt_clr = 1'b0;
    step(); step();
    stall = 1'b0; flush = 1'b1;
    step();
    chk("pre_rst_cnts", {32'd0, stall_cnt, flush_cnt}, {32'd0, 16'd2, 16'd1});
    flush = 1'b0; stall = 1'b1; rst = 1'b1;
    step();
    chk("mid_rst_cnts", {32'd0, stall_cnt, flush_cnt}, 64'd0);
    chk("mid_rst_data", {odata_a, odata_b}, 64'd0);
    chk("mid_rst_misc", {52'd0, eshift, ealuc, ex_destR}, 64'd0);
    rst = 1'b0; stall = 1'b0; id_valid = 1'b1; id_wreg = 1'b1; id_data_a = 32'hCAFE_F00D;
    step();
    chk("resume_valid", {62'd0, ex_valid, ewreg}, 64'd3);
    chk("resume_data_a", {32'd0, odata_a}, {32'd0, 32'hCAFE_F00D});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
